// File: rtl/ctu_dft_jtag_csr_dr.sv
// JTAG data-register bank behind the CTU TAP: IDCODE, CSR address/wdata/rdata
// registers sharing one shift chain, plus a single-outstanding CSR access bridge.
module ctu_dft_jtag_csr_dr #(
  parameter int                     INSTR_WIDTH  = 8,
  parameter int                     ADDR_WIDTH   = 16,
  parameter int                     DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0]  IDCODE_VAL   = 32'h0000_0001,
  parameter logic [INSTR_WIDTH-1:0] OP_IDCODE    = 8'h01,
  parameter logic [INSTR_WIDTH-1:0] OP_CSR_ADDR  = 8'h02,
  parameter logic [INSTR_WIDTH-1:0] OP_CSR_WDATA = 8'h03,
  parameter logic [INSTR_WIDTH-1:0] OP_CSR_RDATA = 8'h04,
  parameter int                     TIMEOUT      = 255
) (
  input  logic                   tck,
  input  logic                   trst,
  input  logic [INSTR_WIDTH-1:0] instructions,
  input  logic                   capture_dr_state,
  input  logic                   shift_dr_state,
  input  logic                   update_dr_state,
  input  logic                   tdi,
  output logic                   so,
  output logic                   bypass_sel,
  output logic                   csr_req,
  output logic                   csr_we,
  output logic [ADDR_WIDTH-1:0]  csr_addr,
  output logic [DATA_WIDTH-1:0]  csr_wdata,
  input  logic                   csr_ack,
  input  logic [DATA_WIDTH-1:0]  csr_rdata
);

  localparam int SW = DATA_WIDTH + 3;
  localparam logic [7:0] TIMEOUT_LD = 8'(TIMEOUT);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t                  state_r, state_next_s;
  logic [SW-1:0]           shift_r, shift_next_s, capture_val_s;
  logic [ADDR_WIDTH-1:0]   addr_r, addr_base_s;
  logic [DATA_WIDTH-1:0]   wdata_r, rdata_r;
  logic [7:0]              cnt_r;
  logic                    overrun_r, error_r, busy_s;
  logic                    sel_idcode_s, sel_addr_s, sel_wdata_s, sel_rdata_s;
  logic                    cap_s, shf_s, upd_s;
  logic                    upd_addr_s, wr_issue_s, rd_issue_s, issue_s, cap_rdata_s;
  logic                    start_s, ack_done_s, timeout_s, drop_s;

  // Instruction decode: anything unrecognised falls through to bypass
  always_comb begin
    sel_idcode_s = 1'b0;
    sel_addr_s   = 1'b0;
    sel_wdata_s  = 1'b0;
    sel_rdata_s  = 1'b0;
    case (instructions)
      OP_IDCODE:    sel_idcode_s = 1'b1;
      OP_CSR_ADDR:  sel_addr_s   = 1'b1;
      OP_CSR_WDATA: sel_wdata_s  = 1'b1;
      OP_CSR_RDATA: sel_rdata_s  = 1'b1;
      default:      sel_idcode_s = 1'b0;
    endcase
  end

  assign bypass_sel = ~(sel_idcode_s | sel_addr_s | sel_wdata_s | sel_rdata_s);
  assign so         = bypass_sel ? 1'b0 : shift_r[0];
  assign busy_s     = (state_r == REQ);

  // Capture takes priority over shift, shift over update
  assign cap_s       = capture_dr_state;
  assign shf_s       = shift_dr_state & ~capture_dr_state;
  assign upd_s       = update_dr_state & ~capture_dr_state & ~shift_dr_state;
  assign upd_addr_s  = upd_s & sel_addr_s;
  assign wr_issue_s  = upd_s & sel_wdata_s;
  assign rd_issue_s  = upd_s & sel_rdata_s;
  assign issue_s     = wr_issue_s | rd_issue_s;
  assign cap_rdata_s = cap_s & sel_rdata_s;

  // Capture value selection, zero-extended to the shared chain width
  always_comb begin
    capture_val_s = '0;
    if (sel_idcode_s) begin
      capture_val_s = {3'b000, IDCODE_VAL};
    end else if (sel_addr_s) begin
      capture_val_s = {{(SW-ADDR_WIDTH){1'b0}}, addr_r};
    end else if (sel_wdata_s) begin
      capture_val_s = {3'b000, wdata_r};
    end else if (sel_rdata_s) begin
      capture_val_s = {overrun_r, error_r, busy_s, rdata_r};
    end else begin
      capture_val_s = shift_r;
    end
  end

  // Shift right; tdi enters at the top bit of the selected register's length
  always_comb begin
    shift_next_s = {1'b0, shift_r[SW-1:1]};
    if (sel_idcode_s || sel_wdata_s) begin
      shift_next_s[DATA_WIDTH-1] = tdi;
    end else if (sel_addr_s) begin
      shift_next_s[ADDR_WIDTH-1] = tdi;
    end else if (sel_rdata_s) begin
      shift_next_s[SW-1] = tdi;
    end else begin
      shift_next_s = shift_r;
    end
  end

  // Access FSM state register
  always_ff @(posedge tck) begin
    if (trst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Access FSM next state and event strobes; ack wins over a same-cycle timeout
  always_comb begin
    state_next_s = state_r;
    start_s      = 1'b0;
    ack_done_s   = 1'b0;
    timeout_s    = 1'b0;
    drop_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (issue_s) begin
          state_next_s = REQ;
          start_s      = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      REQ: begin
        drop_s = issue_s;
        if (csr_ack) begin
          state_next_s = IDLE;
          ack_done_s   = 1'b1;
        end else if (cnt_r <= 8'd1) begin
          state_next_s = IDLE;
          timeout_s    = 1'b1;
        end else begin
          state_next_s = REQ;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // A CSR_ADDR update during REQ retargets the post-ack increment
  assign addr_base_s = upd_addr_s ? shift_r[ADDR_WIDTH-1:0] : addr_r;

  // Data registers, status bits and registered CSR request outputs
  always_ff @(posedge tck) begin
    if (trst) begin
      shift_r   <= '0;
      addr_r    <= '0;
      wdata_r   <= '0;
      rdata_r   <= '0;
      overrun_r <= 1'b0;
      error_r   <= 1'b0;
      cnt_r     <= 8'd0;
      csr_req   <= 1'b0;
      csr_we    <= 1'b0;
      csr_addr  <= '0;
      csr_wdata <= '0;
    end else begin
      if (cap_s) begin
        shift_r <= capture_val_s;
      end else if (shf_s) begin
        shift_r <= shift_next_s;
      end

      addr_r <= ack_done_s ? (addr_base_s + ADDR_ONE) : addr_base_s;

      if (wr_issue_s) begin
        wdata_r <= shift_r[DATA_WIDTH-1:0];
      end

      if (ack_done_s && !csr_we) begin
        rdata_r <= csr_rdata;
      end

      if (timeout_s) begin
        error_r <= 1'b1;
      end else if (cap_rdata_s) begin
        error_r <= 1'b0;
      end

      if (drop_s) begin
        overrun_r <= 1'b1;
      end else if (cap_rdata_s) begin
        overrun_r <= 1'b0;
      end

      if (start_s) begin
        cnt_r     <= TIMEOUT_LD;
        csr_req   <= 1'b1;
        csr_we    <= wr_issue_s;
        csr_addr  <= addr_r;
        csr_wdata <= wr_issue_s ? shift_r[DATA_WIDTH-1:0] : wdata_r;
      end else if (ack_done_s || timeout_s) begin
        csr_req <= 1'b0;
      end else if (busy_s) begin
        cnt_r <= cnt_r - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ctu_dft_jtag_csr_dr.sv
// Directed bench for ctu_dft_jtag_csr_dr: TAP DR scans and CSR handshakes
// with hand-computed expectations (TIMEOUT set to 4).
module tb_ctu_dft_jtag_csr_dr;

  logic        tck = 1'b0;
  logic        trst;
  logic [7:0]  instructions;
  logic        capture_dr_state, shift_dr_state, update_dr_state, tdi;
  logic        so, bypass_sel;
  logic        csr_req, csr_we, csr_ack;
  logic [15:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata;

  int n_checks = 0;
  int n_errors = 0;
  logic [34:0] dout;
  int hi;

  always #5 tck = ~tck;

  ctu_dft_jtag_csr_dr #(.TIMEOUT(4)) dut (
    .tck(tck), .trst(trst), .instructions(instructions),
    .capture_dr_state(capture_dr_state), .shift_dr_state(shift_dr_state),
    .update_dr_state(update_dr_state), .tdi(tdi), .so(so), .bypass_sel(bypass_sel),
    .csr_req(csr_req), .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_ack(csr_ack), .csr_rdata(csr_rdata)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // capture, len shifts of din (LSB first) collecting so, then update
  task automatic dr_scan(input logic [34:0] din, input int len, output logic [34:0] dq);
    dq = '0;
    @(negedge tck); capture_dr_state = 1'b1;
    @(negedge tck); capture_dr_state = 1'b0; shift_dr_state = 1'b1;
    for (int i = 0; i < len; i++) begin
      tdi   = din[i];
      dq[i] = so;
      @(negedge tck);
    end
    shift_dr_state  = 1'b0;
    update_dr_state = 1'b1;
    @(negedge tck); update_dr_state = 1'b0;
  endtask

  // count csr_req-high cycles, acking in cycle delay+1 (bounded)
  task automatic run_ack(input int delay, input logic [31:0] rd, output int n);
    int budget;
    n = 0;
    budget = 0;
    while (csr_req && budget < 64) begin
      n++;
      budget++;
      if (n == delay + 1) begin
        csr_ack = 1'b1; csr_rdata = rd;
      end else begin
        csr_ack = 1'b0;
      end
      @(negedge tck);
    end
    csr_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    trst = 1'b1; instructions = 8'h01;
    capture_dr_state = 1'b0; shift_dr_state = 1'b0; update_dr_state = 1'b0;
    tdi = 1'b0; csr_ack = 1'b0; csr_rdata = 32'h0;
    repeat (2) @(negedge tck);
    trst = 1'b0;
    check_eq("rst_req",   csr_req, 1'b0);
    check_eq("rst_we",    csr_we, 1'b0);
    check_eq("rst_addr",  csr_addr, 16'h0);
    check_eq("rst_wdata", csr_wdata, 32'h0);
    check_eq("rst_so",    so, 1'b0);

    dr_scan(35'h0, 32, dout);
    check_eq("idcode", dout, 35'h0_0000_0001);
    check_eq("idcode_bypass_sel", bypass_sel, 1'b0);

    instructions = 8'h02;
    dr_scan(35'h0010, 16, dout);
    check_eq("addr_cap0", dout, 35'h0);

    instructions = 8'h03;
    dr_scan(35'hDEAD_BEEF, 32, dout);
    check_eq("wr_cap0", dout, 35'h0);
    check_eq("wr_req", csr_req, 1'b1);
    check_eq("wr_we", csr_we, 1'b1);
    check_eq("wr_addr", csr_addr, 16'h0010);
    check_eq("wr_wdata", csr_wdata, 32'hDEAD_BEEF);
    run_ack(3, 32'h0, hi);
    check_eq("wr_req_len", hi, 4);

    instructions = 8'h02;
    dr_scan(35'hFFFF, 16, dout);
    check_eq("addr_inc", dout, 35'h0011);

    instructions = 8'h04;
    dr_scan(35'h0, 35, dout);
    check_eq("rd_cap0", dout, 35'h0);
    check_eq("rd_req", csr_req, 1'b1);
    check_eq("rd_we", csr_we, 1'b0);
    check_eq("rd_addr", csr_addr, 16'hFFFF);
    run_ack(0, 32'h1234_5678, hi);
    check_eq("rd_req_len", hi, 1);

    instructions = 8'h02;
    dr_scan(35'h0, 16, dout);
    check_eq("addr_wrap", dout, 35'h0);

    instructions = 8'h04;
    dr_scan(35'h0, 35, dout);
    check_eq("rdata_cap", dout, {3'b000, 32'h1234_5678});
    check_eq("to_addr", csr_addr, 16'h0000);
    run_ack(1000, 32'h0, hi);
    check_eq("to_req_len", hi, 4);

    dr_scan(35'h0, 35, dout);
    check_eq("err_set", dout, {3'b010, 32'h1234_5678});
    run_ack(0, 32'hA5A5_0F0F, hi);
    check_eq("rd2_len", hi, 1);

    dr_scan(35'h0, 35, dout);
    check_eq("err_clr", dout, {3'b000, 32'hA5A5_0F0F});
    check_eq("rd3_addr", csr_addr, 16'h0001);
    run_ack(1, 32'h0BAD_F00D, hi);
    check_eq("rd3_len", hi, 2);

    instructions = 8'h03;
    dr_scan(35'h1111_2222, 32, dout);
    check_eq("wdata_cap", dout, 35'hDEAD_BEEF);
    check_eq("wr2_wdata", csr_wdata, 32'h1111_2222);
    check_eq("wr2_addr", csr_addr, 16'h0002);
    dr_scan(35'h0, 0, dout);
    run_ack(0, 32'h0, hi);
    check_eq("ovr_len", hi, 1);
    repeat (3) @(negedge tck);
    check_eq("ovr_no_req", csr_req, 1'b0);

    instructions = 8'h04;
    dr_scan(35'h0, 35, dout);
    check_eq("ovr_set", dout, {3'b100, 32'h0BAD_F00D});
    run_ack(0, 32'h0, hi);

    instructions = 8'hFF;
    #1;
    check_eq("byp_sel", bypass_sel, 1'b1);
    check_eq("byp_so", so, 1'b0);
    dr_scan(35'h5_A5A5_A5A5, 32, dout);
    check_eq("byp_stream", dout, 35'h0);
    check_eq("byp_no_req", csr_req, 1'b0);

    instructions = 8'h04;
    dr_scan(35'h0, 35, dout);
    check_eq("ovr_clr", dout, 35'h0);
    check_eq("trst_pre_req", csr_req, 1'b1);
    trst = 1'b1;
    @(negedge tck);
    trst = 1'b0;
    check_eq("trst_req", csr_req, 1'b0);
    dr_scan(35'h0, 35, dout);
    check_eq("trst_status", dout, 35'h0);
    run_ack(0, 32'h0, hi);

    instructions = 8'h02;
    dr_scan(35'h0, 16, dout);
    check_eq("trst_addr", dout, 35'h0001);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
